// File: rtl/fifo_port_sched.sv
// Port scheduler for a single-clock FIFO: round-robin write arbitration across
// NREQ producers, one read consumer, and an internal level count.
//
// Handshake rules: a producer holds req[i] and req_data[i] until it sees gnt[i].
// A word transfers on each rising edge where req[i] & gnt[i] is 1.
// The consumer holds rd_req and is served on each rising edge where rd_ack is 1.
// The data arrives two cycles later, qualified by rd_valid.
module fifo_port_sched #(
  parameter int NREQ  = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int CW    = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  input  logic               rd_req,
  output logic               rd_ack,
  output logic               rd_valid,
  output logic [DW-1:0]      rd_data,
  output logic               fifo_wr,
  output logic               fifo_rd,
  output logic [DW-1:0]      fifo_in_data,
  input  logic [DW-1:0]      fifo_out_data,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  output logic [CW-1:0]      level,
  output logic               err
);

  localparam int RRW = $clog2(NREQ);

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  logic            fifo_wr_q, fifo_wr_d;
  logic            fifo_rd_q, fifo_rd_d;
  logic [DW-1:0]   fifo_in_data_q, fifo_in_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic [CW-1:0]   level_q, level_d;
  logic            err_q, err_d;
  logic [RRW-1:0]  rr_q, rr_d;
  op_e             last_op_q, last_op_d;

  op_e             op_sel;
  logic            wc, rc;
  logic            win_found;
  logic [RRW-1:0]  win_idx;
  logic [RRW-1:0]  cand;

  // Round-robin search starting at rr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    cand      = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = RRW'((int'(rr_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Decisions use only the internal level, never the lagging FIFO flags.
  always_comb begin
    wc     = (|req) && win_found && (level_q < CW'(DEPTH));
    rc     = rd_req && (level_q != '0);
    op_sel = OP_IDLE;
    if (wc && rc) begin
      op_sel = (last_op_q == OP_WRITE) ? OP_READ : OP_WRITE;
    end else if (wc) begin
      op_sel = OP_WRITE;
    end else if (rc) begin
      op_sel = OP_READ;
    end
  end

  always_comb begin
    gnt            = '0;
    rd_ack         = 1'b0;
    fifo_wr_d      = 1'b0;
    fifo_rd_d      = 1'b0;
    fifo_in_data_d = fifo_in_data_q;
    level_d        = level_q;
    rr_d           = rr_q;
    last_op_d      = last_op_q;
    rd_valid_d     = fifo_rd_q;
    err_d          = err_q | (fifo_wr_q & fifo_full) | (fifo_rd_q & fifo_empty);
    case (op_sel)
      OP_WRITE: begin
        gnt[win_idx]   = 1'b1;
        fifo_wr_d      = 1'b1;
        fifo_in_data_d = req_data[int'(win_idx)*DW +: DW];
        level_d        = level_q + CW'(1);
        rr_d           = RRW'((int'(win_idx) + 1) % NREQ);
        last_op_d      = OP_WRITE;
      end
      OP_READ: begin
        rd_ack    = 1'b1;
        fifo_rd_d = 1'b1;
        level_d   = level_q - CW'(1);
        last_op_d = OP_READ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_q      <= 1'b0;
      fifo_rd_q      <= 1'b0;
      fifo_in_data_q <= '0;
      rd_valid_q     <= 1'b0;
      level_q        <= '0;
      err_q          <= 1'b0;
      rr_q           <= '0;
      last_op_q      <= OP_READ;
    end else begin
      fifo_wr_q      <= fifo_wr_d;
      fifo_rd_q      <= fifo_rd_d;
      fifo_in_data_q <= fifo_in_data_d;
      rd_valid_q     <= rd_valid_d;
      level_q        <= level_d;
      err_q          <= err_d;
      rr_q           <= rr_d;
      last_op_q      <= last_op_d;
    end
  end

  assign fifo_wr      = fifo_wr_q;
  assign fifo_rd      = fifo_rd_q;
  assign fifo_in_data = fifo_in_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = fifo_out_data;
  assign level        = level_q;
  assign err          = err_q;

endmodule

// File: tb/tb_fifo_port_sched.sv
// Directed bench for fifo_port_sched with a behavioural 1024-deep FIFO attached.
module tb_fifo_port_sched;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int CW    = 11;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               rd_req;
  logic               rd_ack;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic               fifo_wr;
  logic               fifo_rd;
  logic [DW-1:0]      fifo_in_data;
  logic [DW-1:0]      fifo_out_data;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CW-1:0]      level;
  logic               err;
  logic               force_empty;

  int errors = 0;
  int checks = 0;

  fifo_port_sched #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_in_data(fifo_in_data),
    .fifo_out_data(fifo_out_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .level(level), .err(err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO with registered read data
  logic [DW-1:0] mem [DEPTH];
  int wp, rp, cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 0; rp <= 0; cnt <= 0; fifo_out_data <= '0;
    end else begin
      if (fifo_wr) begin
        mem[wp] <= fifo_in_data;
        wp <= (wp + 1) % DEPTH;
      end
      if (fifo_rd) begin
        fifo_out_data <= mem[rp];
        rp <= (rp + 1) % DEPTH;
      end
      cnt <= cnt + int'(fifo_wr) - int'(fifo_rd);
    end
  end
  assign fifo_empty = force_empty || (cnt == 0);
  assign fifo_full  = (cnt == DEPTH);

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; rd_req = 1'b0; force_empty = 1'b0; req_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; rd_req = 1'b0; force_empty = 1'b0; req_data = '0;
    #12;
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (fifo_wr !== 1'b0 || fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", fifo_wr, fifo_rd); end
    checks++; if (rd_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_valid_err got=%b%b exp=00", rd_valid, err); end
    checks++; if (fifo_in_data !== '0) begin errors++; $display("FAIL reset_in_data got=%h exp=0", fifo_in_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (gnt !== '0 || rd_ack !== 1'b0) begin errors++; $display("FAIL reset_idle got gnt=%b ack=%b exp 0/0", gnt, rd_ack); end
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0001; req_data[15:0] = 16'h1234;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    @(negedge clk);
    req = '0;
    checks++; if (fifo_wr !== 1'b1) begin errors++; $display("FAIL single_fifo_wr got=%b exp=1", fifo_wr); end
    checks++; if (fifo_in_data !== 16'h1234) begin errors++; $display("FAIL single_data got=%h exp=1234", fifo_in_data); end
    checks++; if (level !== 11'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", err); end
    @(negedge clk);
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL single_wr_drop got=%b exp=0", fifo_wr); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_gnt;
    do_reset();
    req_data = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_gnt = 4'b0001 << (c % 4);
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      if (c > 0) begin
        checks++;
        if (fifo_in_data !== 16'h0100 + 16'((c - 1) % 4)) begin
          errors++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, fifo_in_data, 16'h0100 + 16'((c - 1) % 4));
        end
      end
      @(negedge clk);
    end
    req = '0;
    checks++; if (level !== 11'd8) begin errors++; $display("FAIL rr_level got=%0d exp=8", level); end
    checks++; if (fifo_in_data !== 16'h0103) begin errors++; $display("FAIL rr_last_data got=%h exp=0103", fifo_in_data); end
  endtask

  task automatic test_read_latency();
    logic [DW-1:0] words [3];
    words[0] = 16'h000A; words[1] = 16'h000B; words[2] = 16'h000C;
    do_reset();
    req = 4'b0001;
    for (int w = 0; w < 3; w++) begin
      req_data[15:0] = words[w];
      @(negedge clk);
    end
    req = '0;
    checks++; if (level !== 11'd3) begin errors++; $display("FAIL rd_pre_level got=%0d exp=3", level); end
    for (int k = 0; k < 6; k++) begin
      rd_req = (k < 4);
      #1;
      checks++; if (rd_ack !== (k < 3)) begin errors++; $display("FAIL rd_ack k=%0d got=%b exp=%b", k, rd_ack, (k < 3)); end
      checks++; if (rd_valid !== (k >= 2 && k < 5)) begin errors++; $display("FAIL rd_valid k=%0d got=%b exp=%b", k, rd_valid, (k >= 2 && k < 5)); end
      if (k >= 2 && k < 5) begin
        checks++; if (rd_data !== words[k-2]) begin errors++; $display("FAIL rd_data k=%0d got=%h exp=%h", k, rd_data, words[k-2]); end
      end
      if (k == 3) begin
        checks++; if (level !== '0) begin errors++; $display("FAIL rd_level_zero got=%0d exp=0", level); end
      end
      @(negedge clk);
    end
    rd_req = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", err); end
  endtask

  task automatic test_contention();
    do_reset();
    req = 4'b0001;
    for (int w = 0; w < 6; w++) begin
      req_data[15:0] = 16'h0050 + 16'(w);
      @(negedge clk);
    end
    req = '0; rd_req = 1'b1;
    @(negedge clk);
    req = 4'b0001; req_data[15:0] = 16'h00EE;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (gnt !== ((k % 2 == 0) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL cont_gnt k=%0d got=%b", k, gnt); end
      checks++; if (rd_ack !== (k % 2 == 1)) begin errors++; $display("FAIL cont_ack k=%0d got=%b exp=%b", k, rd_ack, (k % 2 == 1)); end
      checks++; if (level !== ((k % 2 == 0) ? 11'd5 : 11'd6)) begin errors++; $display("FAIL cont_level k=%0d got=%0d", k, level); end
      checks++; if (fifo_wr !== (k % 2 == 1) || fifo_rd !== (k % 2 == 0)) begin
        errors++; $display("FAIL cont_strobes k=%0d got wr=%b rd=%b", k, fifo_wr, fifo_rd);
      end
      @(negedge clk);
    end
    req = '0; rd_req = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < DEPTH; c++) begin
      req_data[15:0] = 16'(c);
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL full_fill_gnt c=%0d got=%b", c, gnt); end
      checks++; if (fifo_wr && fifo_full) begin errors++; $display("FAIL full_wr_on_full c=%0d got wr=1 full=1", c); end
      @(negedge clk);
    end
    checks++; if (level !== 11'd1024) begin errors++; $display("FAIL full_level got=%0d exp=1024", level); end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (gnt !== '0) begin errors++; $display("FAIL full_gnt_blocked c=%0d got=%b exp=0000", c, gnt); end
      @(negedge clk);
    end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", fifo_full); end
    rd_req = 1'b1;
    #1;
    checks++; if (rd_ack !== 1'b1 || gnt !== '0) begin errors++; $display("FAIL full_read got ack=%b gnt=%b exp 1/0000", rd_ack, gnt); end
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    checks++; if (level !== 11'd1023) begin errors++; $display("FAIL full_level_after_read got=%0d exp=1023", level); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL full_gnt_resume got=%b exp=0001", gnt); end
    @(negedge clk);
    req = '0;
    checks++; if (level !== 11'd1024) begin errors++; $display("FAIL full_refill got=%0d exp=1024", level); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err got=%b exp=0", err); end
  endtask

  task automatic test_err_and_async_reset();
    do_reset();
    req = 4'b0001; req_data[15:0] = 16'h00AA;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    checks++; if (fifo_rd !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL err_pre got rd=%b err=%b exp 1/0", fifo_rd, err); end
    force_empty = 1'b1;
    @(negedge clk);
    force_empty = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    req = 4'b1111; req_data = {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00};
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_wr !== 1'b0 || fifo_rd !== 1'b0) begin errors++; $display("FAIL async_strobes got wr=%b rd=%b exp 0/0", fifo_wr, fifo_rd); end
    checks++; if (level !== '0) begin errors++; $display("FAIL async_level got=%0d exp=0", level); end
    checks++; if (err !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL async_err_valid got err=%b valid=%b exp 0/0", err, rd_valid); end
    checks++; if (fifo_in_data !== '0 || rd_ack !== 1'b0) begin errors++; $display("FAIL async_data_ack got data=%h ack=%b exp 0/0", fifo_in_data, rd_ack); end
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_latency();
    test_contention();
    test_full();
    test_err_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
